sa_job_scheduler: RTL and testbench
===================================

SA_JOB_SCHEDULER -- requirements
Module: sa_job_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NREQ, 2, number of requesters sharing one serial-adapter core.
- DW, 10, data word width in bits.
- NW, 6, weight-gradient words per job (one per FMAP channel).
- TIMEOUT, 8192, watchdog limit in cycles.

REQ-002 Ports, one per line: name, direction, width, meaning. All outputs registered except fp_done_o.
- clk, in, 1, clock; rising edge active.
- rst, in, 1, reset; asynchronous, active-high.
- req_i, in, NREQ, level request per requester.
- gnt_o, out, NREQ, one-hot grant.
- sel_o, out, clog2(NREQ), owner index; drives external fmap/error muxes.
- core_do_fp_o, out, 1, one-cycle start pulse to the core.
- core_done_fp_i, in, 1, core forward-pass done pulse.
- core_done_bp_i, in, 1, core backprop done pulse.
- core_wchange_i, in, NW*DW, weight gradients from the core.
- core_bchange_i, in, DW, bias gradient from the core.
- fp_done_o, out, NREQ, forwarded forward-pass done, owner bit only, combinational.
- grad_w_o, out, NW*DW, captured weight gradients.
- grad_b_o, out, DW, captured bias gradient.
- grad_valid_o, out, 1, one-cycle pulse; grad outputs valid.
- grad_id_o, out, clog2(NREQ), owner of the captured gradients.
- busy_o, out, 1, high in any state except IDLE and ERROR.
- timeout_o, out, 1, sticky watchdog error.
- clear_err_i, in, 1, clears ERROR.

Function
REQ-003 States: IDLE, START, WAIT_FP, WAIT_BP, RELEASE, ERROR.
REQ-004 IDLE with any req_i bit high: select the owner round-robin, then go to START.
- Search begins at priority pointer ptr, wrapping.
REQ-005 START lasts one cycle: core_do_fp_o=1, gnt_o=onehot(owner), sel_o=owner. Next state is WAIT_FP.
REQ-006 gnt_o and sel_o hold constant from START through RELEASE inclusive.
REQ-007 WAIT_FP: fp_done_o[owner]=core_done_fp_i. On core_done_fp_i go to WAIT_BP.
REQ-008 WAIT_BP: on core_done_bp_i, load grad_w_o, grad_b_o and grad_id_o at that edge, then go to RELEASE.
REQ-009 core_done_fp_i and core_done_bp_i high together in WAIT_FP: forward fp_done_o, capture gradients, go directly to RELEASE.
REQ-010 RELEASE lasts one cycle: grad_valid_o=1. Then ptr=(owner+1) mod NREQ and state returns to IDLE.
REQ-011 A new grant can be issued on the cycle after IDLE is re-entered (one idle cycle minimum between jobs).
REQ-012 Deassertion of req_i mid-job has no effect: the job completes and gradients are still delivered.
REQ-013 Done pulses in IDLE, START, RELEASE or ERROR are ignored. A core_done_bp_i in WAIT_FP without a simultaneous core_done_fp_i is also ignored.
REQ-014 Watchdog counter:
- Cleared in START.
- Increments each cycle in WAIT_FP and WAIT_BP.
- Width clog2(TIMEOUT)+1.
REQ-015 Watchdog expiry: counter reaches TIMEOUT-1 with no terminating done that cycle. Then go to ERROR and set timeout_o=1; gnt_o clears, grad_valid_o stays 0, ptr advances.
REQ-016 ERROR holds until clear_err_i=1, then IDLE with timeout_o cleared. req_i is ignored in ERROR.
REQ-017 Gradient registers hold their value until the next capture. No arithmetic is performed on the data; words pass through bit-exact.

Reset
REQ-018 On rst, asynchronously:
- State IDLE, ptr=0, watchdog=0.
- All outputs 0, including gnt_o, core_do_fp_o, grad registers, grad_valid_o and timeout_o.
REQ-019 Reset during a job abandons it: no grad_valid_o, and the next job restarts from IDLE with ptr=0.

Structure
REQ-020 The state enum, DW and NW belong in the shared CNN package, together with the job-phase encoding reused by the core's FSM.
REQ-021 One sub-module, sa_rr_arbiter: combinational round-robin pick from req_i and ptr, producing a one-hot grant and an index.

Verification
REQ-022 Single job. Stimulus: req_i=01 at cycle 0; core_done_fp_i at cycle 10; core_done_bp_i at cycle 4040 with wchange words 0x101..0x106 and bchange 0x07F.
- gnt_o=01 and core_do_fp_o pulse at cycle 1.
- gnt_o=01 through cycle 4041.
- fp_done_o=01 at cycle 10.
- grad_valid_o at cycle 4041 with grad_w_o 0x101..0x106, grad_b_o 0x07F, grad_id_o 0.
REQ-023 Contention: req_i=11 held for three jobs. Grant order is 0, 1, 0, with exactly one idle cycle between jobs.
REQ-024 Timeout: core_done_bp_i never arrives.
- At WAIT_FP entry+8191: timeout_o=1, gnt_o=00, no grad_valid_o.
- clear_err_i at +8200: back to IDLE next cycle, timeout_o=0.
REQ-025 Simultaneous done: core_done_fp_i and core_done_bp_i together in WAIT_FP. fp_done_o pulses and grad_valid_o follows on the next cycle.
REQ-026 Reset mid-job: rst asserted in WAIT_BP. Outputs clear immediately; a later core_done_bp_i is ignored; a fresh req_i=10 is granted to requester 1.

Source files
------------

// File: rtl/sa_job_scheduler_pkg.sv
// Shared CNN serial-adapter package.
// Holds the scheduler state encoding, the default datapath sizes and the
// job-phase encoding that the core's own FSM reuses.
package sa_job_scheduler_pkg;

   localparam int SA_DW = 10;   // data word width
   localparam int SA_NW = 6;    // weight-gradient words per job

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT_FP = 3'd2,
      ST_WAIT_BP = 3'd3,
      ST_RELEASE = 3'd4,
      ST_ERROR   = 3'd5
   } sched_state_e;

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_FP     = 2'd1,
      PH_BP     = 2'd2,
      PH_UPDATE = 2'd3
   } job_phase_e;

   function automatic logic state_busy(sched_state_e s);
      return (s != ST_IDLE) && (s != ST_ERROR);
   endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - priority pointer; search starts here and wraps
//   gnt   - one-hot grant of the first requester found
//   idx   - index of that requester
//   valid - at least one request present
module sa_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   logic [IW:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!valid && req[cand[IW-1:0]]) begin
            valid               = 1'b1;
            gnt[cand[IW-1:0]]   = 1'b1;
            idx                 = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/sa_job_scheduler.sv
// Shares one serial-adapter core among NREQ requesters, one job at a time.
// A job is: start pulse to the core, wait for forward-pass done, wait for
// backprop done, capture the gradients, release. A watchdog aborts a stuck
// job into a sticky ERROR state that software clears.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   req_i / gnt_o / sel_o         - requests, one-hot grant, owner index
//   core_do_fp_o                  - start pulse to the core
//   core_done_fp_i/core_done_bp_i - core completion pulses
//   core_wchange_i/core_bchange_i - gradients from the core
//   fp_done_o                     - fp done routed to the owner (combinational)
//   grad_w_o/grad_b_o/grad_id_o   - captured gradients and their owner
//   grad_valid_o                  - one-cycle pulse, gradients valid
//   busy_o, timeout_o, clear_err_i - status and error clear
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no job; arbitrate among requesters
// ST_START   | one cycle; start pulse to the core, watchdog cleared
// ST_WAIT_FP | waiting for forward-pass done
// ST_WAIT_BP | waiting for backprop done
// ST_RELEASE | one cycle; gradients valid, pointer advances after
// ST_ERROR   | watchdog expired; held until clear_err_i
module sa_job_scheduler
   import sa_job_scheduler_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int DW      = SA_DW,
   parameter int NW      = SA_NW,
   parameter int TIMEOUT = 8192,
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IW-1:0]    sel_o,
   output logic             core_do_fp_o,
   input  logic             core_done_fp_i,
   input  logic             core_done_bp_i,
   input  logic [NW*DW-1:0] core_wchange_i,
   input  logic [DW-1:0]    core_bchange_i,
   output logic [NREQ-1:0]  fp_done_o,
   output logic [NW*DW-1:0] grad_w_o,
   output logic [DW-1:0]    grad_b_o,
   output logic             grad_valid_o,
   output logic [IW-1:0]    grad_id_o,
   output logic             busy_o,
   output logic             timeout_o,
   input  logic             clear_err_i
);

   localparam int WDW = $clog2(TIMEOUT) + 1;
   // Registered outputs: the expiry decision is taken on the edge where the
   // counter steps to TIMEOUT-1, so timeout_o shows in that same cycle.
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

   sched_state_e state_q, state_d;

   logic [NREQ-1:0]  gnt_q;
   logic [IW-1:0]    sel_q;
   logic             do_fp_q;
   logic [NW*DW-1:0] grad_w_q;
   logic [DW-1:0]    grad_b_q;
   logic [IW-1:0]    grad_id_q;
   logic             grad_valid_q;
   logic             busy_q;
   logic             timeout_q;
   logic [IW-1:0]    ptr_q;
   logic [WDW-1:0]   wd_q;

   logic [NREQ-1:0]  arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_valid;

   logic             grant_ld;
   logic             capture;
   logic             job_end;
   logic             expire;
   logic             wd_clr;
   logic             wd_inc;
   logic             err_clr;
   logic             wd_last;
   logic [IW:0]      sel_inc;
   logic [IW-1:0]    ptr_next;

   sa_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req   (req_i),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // >= rather than == so a job that moved to WAIT_BP on the last counted
   // cycle still expires instead of slipping past the compare.
   assign wd_last = (wd_q >= WD_LAST);

   always_comb begin
      sel_inc  = {1'b0, sel_q} + (IW+1)'(1);
      ptr_next = sel_inc[IW-1:0];
      if (sel_inc >= (IW+1)'(NREQ)) ptr_next = '0;
   end

   always_comb begin
      state_d  = state_q;
      grant_ld = 1'b0;
      capture  = 1'b0;
      job_end  = 1'b0;
      expire   = 1'b0;
      wd_clr   = 1'b0;
      wd_inc   = 1'b0;
      err_clr  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_ld = 1'b1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            wd_clr  = 1'b1;
            state_d = ST_WAIT_FP;
         end
         ST_WAIT_FP: begin
            wd_inc = 1'b1;
            if (core_done_fp_i && core_done_bp_i) begin
               capture = 1'b1;
               state_d = ST_RELEASE;
            end else if (core_done_fp_i) begin
               state_d = ST_WAIT_BP;
            end else if (wd_last) begin
               expire  = 1'b1;
               state_d = ST_ERROR;
            end
         end
         ST_WAIT_BP: begin
            wd_inc = 1'b1;
            if (core_done_bp_i) begin
               capture = 1'b1;
               state_d = ST_RELEASE;
            end else if (wd_last) begin
               expire  = 1'b1;
               state_d = ST_ERROR;
            end
         end
         ST_RELEASE: begin
            job_end = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERROR: begin
            if (clear_err_i) begin
               err_clr = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         sel_q        <= '0;
         do_fp_q      <= 1'b0;
         grad_w_q     <= '0;
         grad_b_q     <= '0;
         grad_id_q    <= '0;
         grad_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         ptr_q        <= '0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         do_fp_q      <= grant_ld;
         grad_valid_q <= capture;
         busy_q       <= state_busy(state_d);
         if (grant_ld) begin
            gnt_q <= arb_gnt;
            sel_q <= arb_idx;
         end
         if (job_end || expire) begin
            gnt_q <= '0;
            ptr_q <= ptr_next;
         end
         if (capture) begin
            grad_w_q  <= core_wchange_i;
            grad_b_q  <= core_bchange_i;
            grad_id_q <= sel_q;
         end
         if (expire)       timeout_q <= 1'b1;
         else if (err_clr) timeout_q <= 1'b0;
         if (wd_clr)       wd_q <= '0;
         else if (wd_inc)  wd_q <= wd_q + WDW'(1);
      end
   end

   assign fp_done_o    = (state_q == ST_WAIT_FP && core_done_fp_i) ? gnt_q : '0;
   assign gnt_o        = gnt_q;
   assign sel_o        = sel_q;
   assign core_do_fp_o = do_fp_q;
   assign grad_w_o     = grad_w_q;
   assign grad_b_o     = grad_b_q;
   assign grad_id_o    = grad_id_q;
   assign grad_valid_o = grad_valid_q;
   assign busy_o       = busy_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Scoreboard bench for sa_job_scheduler: stimulus pushes expected grants
// and gradient deliveries into queues; negedge monitors pop and compare.
module tb_sa_job_scheduler;

   localparam int NREQ    = 2;
   localparam int DW      = 10;
   localparam int NW      = 6;
   localparam int TIMEOUT = 8192;

   logic             clk = 1'b0;
   logic             rst;
   logic [NREQ-1:0]  req_i;
   logic [NREQ-1:0]  gnt_o;
   logic [0:0]       sel_o;
   logic             core_do_fp_o;
   logic             core_done_fp_i;
   logic             core_done_bp_i;
   logic [NW*DW-1:0] core_wchange_i;
   logic [DW-1:0]    core_bchange_i;
   logic [NREQ-1:0]  fp_done_o;
   logic [NW*DW-1:0] grad_w_o;
   logic [DW-1:0]    grad_b_o;
   logic             grad_valid_o;
   logic [0:0]       grad_id_o;
   logic             busy_o;
   logic             timeout_o;
   logic             clear_err_i;

   always #5 clk = ~clk;

   sa_job_scheduler #(
      .NREQ(NREQ), .DW(DW), .NW(NW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .sel_o          (sel_o),
      .core_do_fp_o   (core_do_fp_o),
      .core_done_fp_i (core_done_fp_i),
      .core_done_bp_i (core_done_bp_i),
      .core_wchange_i (core_wchange_i),
      .core_bchange_i (core_bchange_i),
      .fp_done_o      (fp_done_o),
      .grad_w_o       (grad_w_o),
      .grad_b_o       (grad_b_o),
      .grad_valid_o   (grad_valid_o),
      .grad_id_o      (grad_id_o),
      .busy_o         (busy_o),
      .timeout_o      (timeout_o),
      .clear_err_i    (clear_err_i)
   );

   typedef struct {
      int               id;
      logic [NW*DW-1:0] w;
      logic [DW-1:0]    b;
      int               at;
   } grad_t;

   grad_t gq[$];
   int    gntq[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_start(output int s);
      s = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (core_do_fp_o === 1'b1) begin
            s = cyc;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL start_wait: no core_do_fp_o within 12 cycles");
   endtask

   function automatic logic [NW*DW-1:0] pattern(input int base);
      logic [NW*DW-1:0] w;
      w = '0;
      for (int k = 0; k < NW; k++) w[k*DW +: DW] = DW'(base + k);
      return w;
   endfunction

   // grant monitor
   always @(negedge clk) begin
      if (!rst && core_do_fp_o === 1'b1) begin
         if (gntq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: gnt_o=%b", gnt_o);
         end else begin
            int o;
            o = gntq.pop_front();
            check("grant_onehot", 64'(gnt_o), 64'(1) << o);
            check("grant_sel", 64'(sel_o), 64'(o));
         end
      end
   end

   // gradient monitor
   always @(negedge clk) begin
      if (!rst && grad_valid_o === 1'b1) begin
         if (gq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grad_valid: grad_id_o=%0d", grad_id_o);
         end else begin
            grad_t e;
            e = gq.pop_front();
            check("grad_cycle", 64'(cyc), 64'(e.at));
            check("grad_id", 64'(grad_id_o), 64'(e.id));
            check("grad_w", 64'(grad_w_o), 64'(e.w));
            check("grad_b", 64'(grad_b_o), 64'(e.b));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int base, s, prev_bp, err_g, e;
      rst = 1'b1;
      req_i = '0;
      core_done_fp_i = 1'b0;
      core_done_bp_i = 1'b0;
      core_wchange_i = '0;
      core_bchange_i = '0;
      clear_err_i = 1'b0;
      #12;
      check("rst_gnt", 64'(gnt_o), 64'h0);
      check("rst_do_fp", 64'(core_do_fp_o), 64'h0);
      check("rst_busy", 64'(busy_o), 64'h0);
      check("rst_timeout", 64'(timeout_o), 64'h0);
      check("rst_grad_valid", 64'(grad_valid_o), 64'h0);
      check("rst_grad_w", 64'(grad_w_o), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // single job, req dropped mid-job
      base = cyc;
      req_i = 2'b01;
      gntq.push_back(0);
      err_g = 0;
      for (int n = 1; n <= 4042; n++) begin
         tick();
         if (n == 1) check("start_pulse_c1", 64'(core_do_fp_o), 64'h1);
         if (n == 2) check("start_pulse_gone_c2", 64'(core_do_fp_o), 64'h0);
         if (n == 10) begin
            core_done_fp_i = 1'b1;
            #1;
            check("fp_done_c10", 64'(fp_done_o), 64'h1);
         end
         if (n == 11) core_done_fp_i = 1'b0;
         if (n == 20) req_i = 2'b00;
         if (n <= 4041 && gnt_o !== 2'b01) err_g++;
         if (n == 4040) begin
            core_done_bp_i = 1'b1;
            core_wchange_i = pattern(32'h101);
            core_bchange_i = 10'h07F;
            gq.push_back('{0, pattern(32'h101), 10'h07F, cyc + 1});
         end
         if (n == 4041) core_done_bp_i = 1'b0;
         if (n == 4042) begin
            check("gnt_cleared_c4042", 64'(gnt_o), 64'h0);
            check("busy_idle_c4042", 64'(busy_o), 64'h0);
         end
      end
      check("gnt_held_c1_c4041", 64'(err_g), 64'h0);
      check("single_cycle_base", 64'(cyc - base), 64'd4042);

      // simultaneous fp/bp done, requester 1
      req_i = 2'b10;
      gntq.push_back(1);
      wait_start(s);
      tick();
      tick();
      core_done_fp_i = 1'b1;
      core_done_bp_i = 1'b1;
      core_wchange_i = pattern(32'h2A0);
      core_bchange_i = 10'h155;
      gq.push_back('{1, pattern(32'h2A0), 10'h155, cyc + 1});
      #1;
      check("fp_done_simul", 64'(fp_done_o), 64'h2);
      tick();
      core_done_fp_i = 1'b0;
      core_done_bp_i = 1'b0;
      req_i = 2'b00;
      tick();
      tick();
      tick();
      check("grad_hold_b", 64'(grad_b_o), 64'h155);

      // contention: order 0,1,0 with one idle cycle between jobs
      req_i = 2'b11;
      prev_bp = 0;
      for (int k = 0; k < 3; k++) begin
         gntq.push_back((k == 1) ? 1 : 0);
         wait_start(s);
         if (k > 0) check($sformatf("idle_gap_job%0d", k), 64'(s - prev_bp), 64'd3);
         tick();
         tick();
         core_done_fp_i = 1'b1;
         tick();
         core_done_fp_i = 1'b0;
         tick();
         core_done_bp_i = 1'b1;
         core_wchange_i = pattern(32'h300 + 16 * k);
         core_bchange_i = DW'(32'h040 + k);
         gq.push_back('{(k == 1) ? 1 : 0, pattern(32'h300 + 16 * k), DW'(32'h040 + k), cyc + 1});
         prev_bp = cyc;
         if (k == 2) req_i = 2'b00;
         tick();
         core_done_bp_i = 1'b0;
      end
      tick();
      tick();
      tick();

      // timeout: bp never arrives
      req_i = 2'b01;
      gntq.push_back(0);
      wait_start(s);
      e = s + 1;
      req_i = 2'b00;
      while (cyc < e + 8190) begin
         tick();
         if (cyc == e + 5) core_done_fp_i = 1'b1;
         if (cyc == e + 6) core_done_fp_i = 1'b0;
      end
      check("no_timeout_e8190", 64'(timeout_o), 64'h0);
      tick();
      check("timeout_e8191", 64'(timeout_o), 64'h1);
      check("timeout_gnt", 64'(gnt_o), 64'h0);
      check("timeout_busy", 64'(busy_o), 64'h0);
      while (cyc < e + 8200) begin
         tick();
         if (cyc == e + 8193) req_i = 2'b11;
         if (cyc == e + 8198) req_i = 2'b00;
      end
      check("timeout_sticky_e8200", 64'(timeout_o), 64'h1);
      clear_err_i = 1'b1;
      tick();
      clear_err_i = 1'b0;
      check("timeout_cleared", 64'(timeout_o), 64'h0);
      check("idle_after_clear", 64'(busy_o), 64'h0);
      tick();
      tick();

      // reset mid-job in WAIT_BP
      req_i = 2'b01;
      gntq.push_back(0);
      wait_start(s);
      req_i = 2'b00;
      tick();
      core_done_fp_i = 1'b1;
      tick();
      core_done_fp_i = 1'b0;
      tick();
      check("busy_wait_bp", 64'(busy_o), 64'h1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_gnt", 64'(gnt_o), 64'h0);
      check("rst_mid_busy", 64'(busy_o), 64'h0);
      check("rst_mid_grad_b", 64'(grad_b_o), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      core_done_bp_i = 1'b1;
      core_wchange_i = pattern(32'h3F0);
      core_bchange_i = 10'h3FF;
      tick();
      core_done_bp_i = 1'b0;
      tick();
      check("bp_after_rst_ignored", 64'(busy_o), 64'h0);
      req_i = 2'b10;
      gntq.push_back(1);
      wait_start(s);
      tick();
      core_done_fp_i = 1'b1;
      core_done_bp_i = 1'b1;
      core_wchange_i = pattern(32'h011);
      core_bchange_i = 10'h022;
      gq.push_back('{1, pattern(32'h011), 10'h022, cyc + 1});
      tick();
      core_done_fp_i = 1'b0;
      core_done_bp_i = 1'b0;
      req_i = 2'b00;
      tick();
      tick();
      tick();

      check("grant_queue_drained", 64'(gntq.size()), 64'h0);
      check("grad_queue_drained", 64'(gq.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
